// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the branch predictor.
// Tags are stored zero-extended to TAG_W_MAX so the entry type stays parameter-free.
package bp_pkg;

    localparam int TAG_W_MAX = 24;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
        logic [31:0]          target;
        logic [1:0]           ctr;
    } btb_entry_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_ctr
);

    assign o_ctr = i_taken ? sat_inc(i_ctr) : sat_dec(i_ctr);

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: same-cycle lookup for IF,
// learning and mispredict/redirect from branches resolved in EX.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W         = 6,
    parameter int TAG_W         = 8,
    parameter int RESET_PC_STEP = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_br,
    input  logic        i_ex_is_jal,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pred_target,
    output logic        o_mispredict,
    output logic [31:0] o_redirect_pc
);

    localparam int ENTRIES = 1 << IDX_W;

    btb_entry_t r_btb [ENTRIES];

    logic [IDX_W-1:0]     w_if_idx, w_ex_idx;
    logic [TAG_W_MAX-1:0] w_if_tag, w_ex_tag;
    btb_entry_t           w_if_ent;
    logic                 w_if_hit, w_ex_hit;
    logic                 w_res, w_taken;
    logic [1:0]           w_ctr_nxt;
    logic                 w_unused;

    assign w_if_idx = i_if_pc[IDX_W+1:2];
    assign w_if_tag = TAG_W_MAX'(i_if_pc[IDX_W+TAG_W+1:IDX_W+2]);
    assign w_ex_idx = i_ex_pc[IDX_W+1:2];
    assign w_ex_tag = TAG_W_MAX'(i_ex_pc[IDX_W+TAG_W+1:IDX_W+2]);
    assign w_unused = ^{i_if_pc[1:0], i_if_pc[31:IDX_W+TAG_W+2]};

    // Lookup reads the registered table only, so an update in flight is not bypassed
    assign w_if_ent      = r_btb[w_if_idx];
    assign w_if_hit      = w_if_ent.valid && (w_if_ent.tag == w_if_tag);
    assign o_pred_taken  = !i_reset && w_if_hit && w_if_ent.ctr[1];
    assign o_pred_target = o_pred_taken ? w_if_ent.target : 32'd0;

    assign w_res        = i_ex_valid && (i_ex_is_br || i_ex_is_jal);
    assign o_mispredict = !i_reset && w_res &&
                          ((i_ex_taken != i_ex_pred_taken) ||
                           (i_ex_taken && (i_ex_target != i_ex_pred_target)));
    assign o_redirect_pc = !o_mispredict ? 32'd0 :
                           i_ex_taken    ? i_ex_target :
                                           i_ex_pc + 32'(RESET_PC_STEP);

    // A JAL trains as taken even if the outcome bit was left low
    assign w_taken  = i_ex_taken || i_ex_is_jal;
    assign w_ex_hit = r_btb[w_ex_idx].valid && (r_btb[w_ex_idx].tag == w_ex_tag);

    bp_sat_counter u_ctr (
        .i_ctr   (r_btb[w_ex_idx].ctr),
        .i_taken (w_taken),
        .o_ctr   (w_ctr_nxt)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i] <= '{valid: 1'b0, tag: '0, target: 32'd0, ctr: CTR_WNT};
            end
        end else if (w_res) begin
            if (w_ex_hit) begin
                r_btb[w_ex_idx].ctr <= w_ctr_nxt;
                if (w_taken) r_btb[w_ex_idx].target <= i_ex_target;
            end else if (w_taken) begin
                r_btb[w_ex_idx] <= '{valid:  1'b1,
                                     tag:    w_ex_tag,
                                     target: i_ex_target,
                                     ctr:    i_ex_is_jal ? CTR_ST : CTR_WT};
            end
        end
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side partner of the EX-stage branch comparator: predicts taken/not-taken and target for the PC in IF.
- Learns from branch outcomes resolved in EX by the comparator and branch logic.
- Direct-mapped BTB plus a 2-bit saturating counter per entry.
- Raises the mispredict and redirect signals that flush IF/ID and steer the PC mux.

Parameters:
- IDX_W, 6, BTB index width (2^IDX_W entries).
- TAG_W, 8, stored tag width.
- RESET_PC_STEP, 4, increment for the fall-through PC on a not-taken redirect.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_if_pc  in  32  PC being fetched.
- o_pred_taken  out  1  prediction for i_if_pc.
- o_pred_target  out  32  predicted target; 0 when o_pred_taken=0.
- i_ex_valid  in  1  EX stage holds a valid instruction.
- i_ex_is_br  in  1  EX instruction is a conditional branch.
- i_ex_is_jal  in  1  EX instruction is JAL.
- i_ex_pc  in  32  PC of the EX instruction.
- i_ex_taken  in  1  resolved outcome (from comparator + funct3 decode).
- i_ex_target  in  32  resolved target.
- i_ex_pred_taken  in  1  prediction carried down the pipe with this instruction.
- i_ex_pred_target  in  32  predicted target carried down the pipe.
- o_mispredict  out  1  flush IF/ID this cycle.
- o_redirect_pc  out  32  correct next PC when o_mispredict=1, else 0.

Behaviour:
- Address split:
  - idx = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
- Entry fields: valid, tag, target[31:0], ctr[1:0].
- Reset:
  - Takes effect at the first i_clk edge with i_reset=1.
  - All valid bits clear; all ctr set to 2'b01.
  - While i_reset=1, o_pred_taken=0, o_pred_target=0, o_mispredict=0, o_redirect_pc=0.
- Lookup:
  - Combinational, same cycle.
  - hit = valid[idx] & tag match.
  - o_pred_taken = hit & ctr[1].
  - o_pred_target = target when o_pred_taken=1, else 0.
- Resolve event: res = i_ex_valid & (i_ex_is_br | i_ex_is_jal).
- Mispredict:
  - Combinational: res & ((i_ex_taken != i_ex_pred_taken) | (i_ex_taken & (i_ex_target != i_ex_pred_target))).
  - o_redirect_pc = i_ex_taken ? i_ex_target : i_ex_pc + RESET_PC_STEP.
  - Fall-through add wraps modulo 2^32.
- Update on the clock edge when res=1, indexed by i_ex_pc:
  - Hit, taken: ctr = sat_inc(ctr) (saturates at 2'b11); target <= i_ex_target.
  - Hit, not taken: ctr = sat_dec(ctr) (saturates at 2'b00); target unchanged.
  - Miss, taken: allocate (valid=1, tag, target). ctr = 2'b11 for JAL, 2'b10 for a branch. Any other entry at that index is evicted.
  - Miss, not taken: no write.
  - JAL always counts as taken, regardless of i_ex_taken.
- Latency:
  - A write becomes visible to lookup on the cycle after the edge.
  - Same-cycle lookup and update of the same idx returns the old contents; no bypass.
- Unresolved cycles: i_ex_valid=0, or a non-branch instruction, gives no update and o_mispredict=0.
- Flush interplay: the caller deasserts i_ex_valid for flushed instructions; the block never self-suppresses.
- Reset asserted in the same cycle as res=1: reset wins and no update is written.
- Unknown-free: all table registers are initialised by reset; no X propagation from the table.

Decomposition:
- Shared package bp_pkg:
  - btb_entry_t struct (valid, tag, target, ctr).
  - Counter constants CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - Functions sat_inc/sat_dec.
- One natural sub-module: bp_sat_counter. Pure next-state function of the 2-bit counter given a taken input; instantiated once on the update path.

Test Plan:
- Reset, then lookup 0x0000_0100 -> o_pred_taken=0, o_pred_target=0.
- Branch at 0x100 resolves taken to 0x80 with pred 0 -> o_mispredict=1, redirect=0x80. Next cycle, lookup 0x100 -> pred_taken=1, target=0x80, ctr=10.
- Same branch resolved not taken twice -> ctr 10 -> 01 -> 00; lookup then gives pred 0. A third not-taken keeps ctr=00 (saturation). A not-taken with pred 0 -> o_mispredict=0.
- Taken four times from 00 -> ctr 01, 10, 11, 11 (saturates). A correct prediction with matching target -> o_mispredict=0. Same direction but target 0x90 vs predicted 0x80 -> o_mispredict=1, redirect=0x90.
- Alias: JAL at 0x100 + (1<<(IDX_W+2)) taken -> evicts the 0x100 entry with ctr=11; lookup 0x100 -> pred 0 (tag miss).
- Reset asserted with res=1 on branch 0x200 taken -> no allocation, o_mispredict=0. After reset, lookup 0x200 -> pred 0.
